// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d, rd_data_q, rd_data_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            sel_rem_q, sel_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic            signed_op, rs1_neg, rs2_neg, div_zero, overflow, last;
  logic [XLEN-1:0] rs1_mag, rs2_mag, special_res, quo_nxt, rem_nxt, quo_fix, rem_fix;
  logic [XLEN:0]   trial, diff;

  always_comb begin
    signed_op   = ~i_op[0];
    rs1_neg     = signed_op & i_rs1_data[XLEN-1];
    rs2_neg     = signed_op & i_rs2_data[XLEN-1];
    rs1_mag     = rs1_neg ? -i_rs1_data : i_rs1_data;
    rs2_mag     = rs2_neg ? -i_rs2_data : i_rs2_data;
    div_zero    = i_rs2_data == '0;
    overflow    = signed_op && i_rs1_data == MIN_NEG && i_rs2_data == '1;
    special_res = i_op[1] ? (div_zero ? i_rs1_data : '0) : (div_zero ? '1 : MIN_NEG);
  end

  // The shifted partial remainder needs one extra bit so the borrow of the trial subtract is visible.
  always_comb begin
    trial   = {rem_q, quo_q[XLEN-1]};
    diff    = trial - {1'b0, dvs_q};
    rem_nxt = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
    quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
    last    = cnt_q == CW'(XLEN-1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (i_start && !i_kill) begin
          rd_addr_d = i_rd_addr;
          sel_rem_d = i_op[1];
          if (div_zero || overflow) begin
            rd_data_d = special_res;
            state_d   = DONE;
          end else begin
            dvs_d     = rs2_mag;
            quo_d     = rs1_mag;
            rem_d     = '0;
            neg_quo_d = rs1_neg ^ rs2_neg;
            neg_rem_d = rs1_neg;
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (i_kill) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = last ? cnt_q : cnt_q + CW'(1);
          if (last) begin
            rd_data_d = sel_rem_q ? rem_fix : quo_fix;
            state_d   = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign o_busy    = state_q != IDLE;
  assign o_done    = state_q == DONE;
  assign o_rd_wren = o_done && (rd_addr_q != 5'd0) && !i_kill;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: random and directed stimulus for div_unit, checked every cycle against a cycle-count/arithmetic model.
module tb_div_unit;
  logic        i_clk, i_reset, i_start, i_kill;
  logic [1:0]  i_op;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_busy, o_done, o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  div_unit #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .i_kill(i_kill), .o_busy(o_busy), .o_done(o_done), .o_rd_addr(o_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0, cyc = 0, ndone = 0;
  int cs = 0, busy_end = -1, done_cyc = -1, start_cyc = 0, last_done_cyc = 0;
  logic [31:0] exp_new = '0, exp_data = '0, last_data = '0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] regs [32];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one sample per cycle, mid-cycle, after the driver has set this cycle's inputs.
  always @(negedge i_clk) begin
    logic bus, dn;
    #1;
    cyc++;
    bus = cyc >= cs && cyc <= busy_end;
    dn  = cyc == done_cyc;
    if (dn) exp_data = exp_new;
    check("busy", 32'(o_busy), 32'(bus));
    check("done", 32'(o_done), 32'(dn));
    check("rd_data", o_rd_data, exp_data);
    check("rd_wren", 32'(o_rd_wren), 32'(dn && exp_addr != 0 && !i_kill && i_reset));
    if (dn) check("rd_addr", 32'(o_rd_addr), 32'(exp_addr));
    if (!i_reset) check("rst_addr", 32'(o_rd_addr), 32'h0);
    if (o_done) begin
      ndone++;
      last_data     = o_rd_data;
      last_done_cyc = cyc;
    end
    if (o_rd_wren) regs[o_rd_addr] = o_rd_data;
  end

  task automatic step(input logic st, input logic kl, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int cur;
    logic busy, calc, special;
    @(negedge i_clk);
    i_start = st; i_kill = kl; i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd;
    cur  = cyc + 1;
    busy = cur >= cs && cur <= busy_end;
    calc = busy && cur != done_cyc;
    if (kl && calc) begin
      busy_end = cur;
      done_cyc = -1;
    end else if (!busy && st && !kl) begin
      special   = b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      cs        = cur + 1;
      done_cyc  = cs + (special ? 0 : 32);
      busy_end  = done_cyc;
      exp_new   = model(op, a, b);
      exp_addr  = rd;
      start_cyc = cur;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'($urandom), $urandom, $urandom, 5'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    i_reset = 1'b0; i_start = 1'b0; i_kill = 1'b0;
    busy_end = -1; done_cyc = -1; exp_data = '0;
    #2;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_rd_data", o_rd_data, 32'h0);
    repeat (n) @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] want, input int lat);
    int n0;
    n0 = ndone;
    step(1'b1, 1'b0, op, a, b, rd);
    for (int i = 0; i < 40 && ndone == n0; i++) idle(1);
    check({nm, "_count"}, 32'(ndone - n0), 32'd1);
    check({nm, "_data"}, last_data, want);
    check({nm, "_lat"}, 32'(last_done_cyc - start_cyc), 32'(lat));
    idle(2);
  endtask

  initial begin
    int n0;
    i_clk = 0; i_reset = 1; i_start = 0; i_kill = 0; i_op = 0;
    i_rs1_data = 0; i_rs2_data = 0; i_rd_addr = 0;
    foreach (regs[i]) regs[i] = '0;
    #1 i_reset = 0;
    repeat (3) @(negedge i_clk);
    i_reset = 1;
    idle(3);
    check("idle_busy", 32'(o_busy), 32'h0);
    check("idle_data", o_rd_data, 32'h0);
    check("model_div", model(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem", model(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_ovf", model(2'd0, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    run_op("divu", 2'd1, 32'd100, 32'd7, 5'd5, 32'h0000_000E, 33);
    check("reg5", regs[5], 32'h0000_000E);
    run_op("remu", 2'd3, 32'd100, 32'd7, 5'd5, 32'h0000_0002, 33);
    run_op("div_neg", 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
    run_op("rem_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("div_nn", 2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd6, 32'h0000_0003, 33);
    run_op("divu_z", 2'd1, 32'h1234_5678, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    run_op("rem_z", 2'd2, 32'h1234_5678, 32'd0, 5'd7, 32'h1234_5678, 1);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0, 1);
    run_op("rd0", 2'd1, 32'd50, 32'd5, 5'd0, 32'h0000_000A, 33);

    n0 = ndone;
    step(1'b1, 1'b0, 2'd1, 32'd1000, 32'd3, 5'd9);
    idle(9);
    step(1'b1, 1'b0, 2'd1, 32'd55, 32'd5, 5'd10);
    idle(40);
    check("ignored_start_count", 32'(ndone - n0), 32'd1);
    check("ignored_start_data", last_data, 32'd333);

    n0 = ndone;
    step(1'b1, 1'b0, 2'd1, 32'd1000, 32'd3, 5'd11);
    idle(11);
    step(1'b0, 1'b1, 2'd1, 32'd0, 32'd0, 5'd0);
    idle(40);
    check("kill_calc_count", 32'(ndone - n0), 32'd0);

    regs[12] = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, 2'd3, 32'd77, 32'd0, 5'd12);
    step(1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 5'd0);
    idle(3);
    check("kill_done_reg", regs[12], 32'hDEAD_BEEF);

    step(1'b1, 1'b0, 2'd1, 32'd1000, 32'd3, 5'd13);
    idle(5);
    do_reset(2);
    run_op("post_rst", 2'd1, 32'd9, 32'd3, 5'd14, 32'h0000_0003, 33);

    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2, 2'($urandom),
           pick(), pick(), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
